// File: rtl/alu16.sv
// alu16: 16-bit execute-stage ALU with registered result and zero flag.
// The operation comes straight from alu_op (ADD/SUB/AND), or, when
// alu_op = 2'b11, from a one-hot R-type func field. Multi-hot func values
// resolve to the lowest set bit.
// Optional build macro ALU_FLAGS_EN adds registered carry, overflow and
// negative outputs.
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_op,
    input  logic [7:0]       func,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow,
    output logic             negative
`endif
);

    localparam int MSB = WIDTH - 1;

    // Resolved operation, after the alu_op and func decode.
    typedef enum logic [2:0] {
        K_MOV,
        K_ADD,
        K_SUB,
        K_AND,
        K_OR,
        K_NOT,
        K_NOP,
        K_ZERO
    } kind_e;

    kind_e            kind;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] nxt_result;

`ifdef ALU_FLAGS_EN
    logic add_c;
    logic sub_c;
    logic add_v;
    logic sub_v;
    logic nxt_carry;
    logic nxt_ovf;

    // Keep the carry out so it can become the flag. SUB is a + ~b + 1, so
    // its carry out is the no-borrow flag.
    assign {add_c, add_res} = {1'b0, a} + {1'b0, b};
    assign {sub_c, sub_res} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // Signed overflow: the operand signs allow it, and the result sign
    // differs from the sign of a.
    assign add_v = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
    assign sub_v = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
`else
    assign add_res = a + b;
    assign sub_res = a + ~b + WIDTH'(1);
`endif

    // Decode alu_op and func into a single operation.
    // func is a priority encoder from bit 0. Zero and reserved produce 0.
    always_comb begin
        // NOTE: default assignment first so every path assigns kind and no latch is inferred.
        kind = K_ZERO;
        case (alu_op)
            2'b00: kind = K_ADD;
            2'b01: kind = K_SUB;
            2'b10: kind = K_AND;
            default: begin
                casez (func)
                    8'b???????1: kind = K_MOV;
                    8'b??????10: kind = K_ADD;
                    8'b?????100: kind = K_SUB;
                    8'b????1000: kind = K_AND;
                    8'b???10000: kind = K_OR;
                    8'b??100000: kind = K_NOT;
                    8'b?1000000: kind = K_NOP;
                    default:     kind = K_ZERO;
                endcase
            end
        endcase
    end

    // Result mux for the value to be captured.
    always_comb begin
        nxt_result = '0;
        case (kind)
            K_MOV:   nxt_result = b;
            K_ADD:   nxt_result = add_res;
            K_SUB:   nxt_result = sub_res;
            K_AND:   nxt_result = a & b;
            K_OR:    nxt_result = a | b;
            K_NOT:   nxt_result = ~b;
            default: nxt_result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Carry and overflow are meaningful only for ADD and SUB. They are
    // cleared for every other operation.
    always_comb begin
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        if (kind == K_ADD) begin
            nxt_carry = add_c;
            nxt_ovf   = add_v;
        end else if (kind == K_SUB) begin
            nxt_carry = sub_c;
            nxt_ovf   = sub_v;
        end
    end
`endif

    // Output registers. They capture on en unless the operation is NOP.
    // zero is derived from the same value that is loaded into result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
            result   <= '0;
            zero     <= 1'b1;
`ifdef ALU_FLAGS_EN
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
`endif
        end else if (en && (kind != K_NOP)) begin
            result   <= nxt_result;
            zero     <= (nxt_result == '0);
`ifdef ALU_FLAGS_EN
            carry    <= nxt_carry;
            overflow <= nxt_ovf;
            negative <= nxt_result[MSB];
`endif
        end
    end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: self-checking bench for alu16. It compares the DUT against an
// arithmetic reference model, using directed cases followed by $urandom
// vectors. Build with ALU_FLAGS_EN defined to include the flag outputs.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  alu_op;
    logic [7:0]  func;
    logic [15:0] result;
    logic        zero;
`ifdef ALU_FLAGS_EN
    logic        carry;
    logic        overflow;
    logic        negative;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Expected register contents, maintained by the reference model.
    logic [15:0] exp_r;
    logic        exp_z;
    logic        exp_c;
    logic        exp_v;
    logic        exp_n;

    alu16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .func     (func),
        .result   (result),
        .zero     (zero)
`ifdef ALU_FLAGS_EN
        ,
        .carry    (carry),
        .overflow (overflow),
        .negative (negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model, computed from plain integer arithmetic.
    // hold = 1 means NOP, so no capture takes place.
    function automatic void ref_alu(input logic [15:0] ra, input logic [15:0] rb,
                                    input logic [1:0] op, input logic [7:0] fn,
                                    output bit hold, output logic [15:0] r,
                                    output logic c, output logic v);
        int k;
        int s;
        int sa;
        int sb;
        hold = 1'b0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        sa   = int'($signed(ra));
        sb   = int'($signed(rb));
        if (op == 2'd3) begin
            k = 8;
            for (int i = 7; i >= 0; i--)
                if (fn[i]) k = i;
        end else begin
            k = int'(op) + 1;            // 0->ADD(1), 1->SUB(2), 2->AND(3)
        end
        case (k)
            0: r = rb;
            1: begin
                s = int'(ra) + int'(rb);
                r = s[15:0];
                c = (s > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            2: begin
                s = int'(ra) - int'(rb);
                r = s[15:0];
                c = (ra >= rb);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3: r = ra & rb;
            4: r = ra | rb;
            5: r = ~rb;
            6: hold = 1'b1;
            default: r = '0;
        endcase
    endfunction

    task automatic model_reset();
        exp_r = '0;
        exp_z = 1'b1;
        exp_c = 1'b0;
        exp_v = 1'b0;
        exp_n = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, 16'(zero), 16'(exp_z));
`ifdef ALU_FLAGS_EN
        check({tag, ".carry"}, 16'(carry), 16'(exp_c));
        check({tag, ".overflow"}, 16'(overflow), 16'(exp_v));
        check({tag, ".negative"}, 16'(negative), 16'(exp_n));
`endif
    endtask

    // Drive one vector just after a falling edge, clock it through, then
    // compare on the following falling edge.
    task automatic step(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [1:0] op, input logic [7:0] fn, input logic te);
        bit          hold;
        logic [15:0] r;
        logic        c;
        logic        v;
        a      = ta;
        b      = tb_;
        alu_op = op;
        func   = fn;
        en     = te;
        @(posedge clk);
        ref_alu(ta, tb_, op, fn, hold, r, c, v);
        if (rst_n && te && !hold) begin
            exp_r = r;
            exp_z = (r == 16'h0000);
            exp_c = c;
            exp_v = v;
            exp_n = r[15];
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Assert reset partway through the low phase and check the outputs
    // before any clock edge. Keep reset held across one enabled edge, then
    // release it on a falling edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        a      = 16'(($urandom));
        b      = 16'(($urandom));
        alu_op = 2'd0;
        func   = 8'h00;
        en     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_outputs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        a      = '0;
        b      = '0;
        alu_op = '0;
        func   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Directed cases.
        step("add_func_ignored", 16'h0003, 16'h0002, 2'b00, 8'h08, 1'b1);
        check("add_lit", result, 16'h0005);
        async_reset("midstream");
        check("reset_lit", result, 16'h0000);
        step("after_release", 16'h0003, 16'h0002, 2'b00, 8'h08, 1'b1);
        check("release_lit", result, 16'h0005);
        step("sub", 16'h0003, 16'h0002, 2'b01, 8'h00, 1'b1);
        check("sub_lit", result, 16'h0001);
        step("sub_eq", 16'h0007, 16'h0007, 2'b01, 8'h00, 1'b1);
        check("sub_eq_zero", 16'(zero), 16'h0001);
        step("sub_borrow", 16'h0002, 16'h0003, 2'b01, 8'h00, 1'b1);
        step("and_op", 16'hF0F3, 16'h0FF2, 2'b10, 8'h40, 1'b1);
        step("r_or", 16'h0003, 16'h0002, 2'b11, 8'h10, 1'b1);
        check("or_lit", result, 16'h0003);
        step("r_not", 16'h0003, 16'h0002, 2'b11, 8'h20, 1'b1);
        check("not_lit", result, 16'hFFFD);
        step("r_nop", 16'h0003, 16'h0002, 2'b11, 8'h40, 1'b1);
        check("nop_lit", result, 16'hFFFD);
        step("add_wrap", 16'hFFFF, 16'h0001, 2'b00, 8'h00, 1'b1);
        check("wrap_zero", 16'(zero), 16'h0001);
        step("add_ovf", 16'h7FFF, 16'h0001, 2'b00, 8'h00, 1'b1);
        check("ovf_lit", result, 16'h8000);
        for (int i = 0; i < 3; i++)
            step("en_low", 16'($urandom), 16'($urandom), 2'($urandom), 8'($urandom), 1'b0);
        check("en_low_lit", result, 16'h8000);
        step("multi_0c", 16'h0003, 16'h0002, 2'b11, 8'h0C, 1'b1);
        check("multi_0c_lit", result, 16'h0001);
        step("multi_18", 16'h0003, 16'h0002, 2'b11, 8'h18, 1'b1);
        check("multi_18_lit", result, 16'h0002);
        step("multi_41", 16'h0003, 16'h1234, 2'b11, 8'h41, 1'b1);
        step("func_zero", 16'h0003, 16'h0002, 2'b11, 8'h00, 1'b1);
        step("r_mov", 16'h0003, 16'h8002, 2'b11, 8'h01, 1'b1);
        step("reserved", 16'h0003, 16'h0002, 2'b11, 8'h80, 1'b1);
        step("r_sub", 16'h8000, 16'h0001, 2'b11, 8'h04, 1'b1);

        // Random vectors, with an occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [7:0]  fn;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            fn = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            if ($urandom_range(0, 59) == 0)
                async_reset("rand");
            step("rand", ra, rb, 2'($urandom), fn, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
